quadrature_counter: RTL and testbench
=====================================

Name: quadrature_counter

Overview:
- Decodes a motor's quadrature encoder channels A/B into a signed 36-bit position count.
- The count is sampled every 5 ms by the downstream velocity (RPM) derivative stage.
- Sits between the encoder pins and the velocity stage, in the main system clock domain.
- Synchronises and glitch-filters the raw pins, decodes x4, and reports direction and illegal transitions.

Parameters:
- FILTER_LEN, 4, consecutive clk cycles a synchronised channel must hold a level before it is accepted; legal range 1..255.
- DIR_INVERT, 0, when 1 swaps the increment/decrement sense. Used for mirrored motor mounting.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous reset, active low
- enc_a  input  1  raw encoder channel A, asynchronous to clk
- enc_b  input  1  raw encoder channel B, asynchronous to clk
- clear  input  1  synchronous count clear, one cycle pulse or level
- count  output  36 signed  present encoder count
- direction  output  1  1 = last accepted step incremented, 0 = decremented
- step_pulse  output  1  one-cycle pulse on each accepted step
- err_pulse  output  1  one-cycle pulse on each illegal transition
- err_cnt  output  8  saturating count of illegal transitions

Behaviour:
- Clock and reset: single clock `clk`. `reset_n` is synchronous and active low, sampled on the rising edge of `clk`.
- Reset values:
  - count = 0, direction = 0, step_pulse = 0, err_pulse = 0, err_cnt = 0.
  - Synchroniser flops = 0, filter counters = 0, filtered A/B = 0, primed = 0.
- Synchroniser: two flip-flop stages per channel (s1, s2).
- Glitch filter:
  - Each channel has a stability counter, reset to 0 whenever s2 differs from its value on the previous cycle.
  - When s2 has been constant for FILTER_LEN consecutive cycles, the filtered level takes s2.
  - Any pulse shorter than FILTER_LEN cycles after synchronisation is discarded.
- Priming:
  - The first time both channels become stable after reset, the filtered state {A,B} is loaded with `primed` set to 1.
  - No step and no error are generated on that load, whatever the pin levels.
- Decode:
  - Transitions are evaluated in registered {A,B} filtered state, comparing the new state against the previous one.
  - Forward sequence is 00→10→11→01→00, i.e. A leads B. Each forward step does count+1 and sets direction = 1.
  - The reverse sequence does count−1 and sets direction = 0.
  - DIR_INVERT = 1 swaps both the count sign and the direction value.
  - No change: nothing happens.
  - Both bits change in the same evaluation: illegal. count and direction are unchanged, err_pulse = 1 for one cycle, err_cnt increments, saturating at 255.
- Latency:
  - count, direction and step_pulse update together on the (FILTER_LEN+3)th rising edge, counting the edge that first samples the new pin level as edge 1.
  - Fixed latency: 7 edges at default.
- Arithmetic:
  - count is two's complement 36-bit and wraps silently: +1 from 2^35−1 gives −2^35, −1 from −2^35 gives 2^35−1.
  - Downstream differencing tolerates the wrap.
- clear:
  - count = 0 on the next edge.
  - clear has priority over a simultaneous step: the step is lost and step_pulse still pulses.
  - clear does not affect err_cnt, direction, the filters or the primed state.
- Reset mid-operation:
  - All state returns to reset values, including primed = 0.
  - The next stable state re-primes without counting.
- Simultaneous channel settling: A and B filters complete on the same cycle, seen as a two-bit change, which is handled as illegal (once primed).

Test Plan:
- Reset then pins held at A=1, B=1: after priming, count = 0, err_cnt = 0, no step_pulse.
- 8 forward quadrature cycles (32 edges, each level held 20 clk) → count = 32, direction = 1, 32 step_pulses. Then 8 reverse cycles → count = 0, direction = 0.
- Single A edge, latency check: count changes on edge 7 with FILTER_LEN = 4. Also a 3-cycle glitch on B → no count change, no pulses.
- Force {A,B} 00→11 in one step → err_pulse once, err_cnt = 1, count unchanged. 300 illegal steps → err_cnt = 255.
- Preload count to 2^35−1 via forward steps (bench-forced state acceptable), then one more forward step → count = −2^35. One reverse step → 2^35−1.
- clear asserted on the same cycle as a forward step with count = 10 → count = 0, step_pulse = 1. DIR_INVERT = 1 instance with forward sequence → count decrements, direction = 0.

Source files
------------

// File: rtl/quadrature_counter.sv
// Quadrature encoder x4 decoder: synchronise, glitch-filter, decode A/B into a signed 36-bit count.
// Latency FILTER_LEN+3 clk edges from pin to count; no backpressure, every accepted step is counted.
module quadrature_counter #(
    parameter int FILTER_LEN = 4,
    parameter bit DIR_INVERT = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clear,
    output logic signed [35:0] count,
    output logic               direction,
    output logic               step_pulse,
    output logic               err_pulse,
    output logic [7:0]         err_cnt
);

    localparam logic [7:0] FLEN = 8'(FILTER_LEN);

    // Bit 1 carries channel A, bit 0 channel B, so the pair reads as {A,B}.
    logic [1:0]      sync_s1;
    logic [1:0]      sync_s2;
    logic [1:0]      sync_s2_d;
    logic [1:0]      filt;
    logic [1:0][7:0] stab_cnt;
    logic [1:0]      stable;

    // stab_cnt is the run length of the current s2 level; the level is taken
    // on the edge at which the run reaches FILTER_LEN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_s1   <= '0;
            sync_s2   <= '0;
            sync_s2_d <= '0;
            filt      <= '0;
            stab_cnt  <= '0;
        end else begin
            sync_s1   <= {enc_a, enc_b};
            sync_s2   <= sync_s1;
            sync_s2_d <= sync_s2;
            for (int i = 0; i < 2; i++) begin
                if (sync_s2[i] != sync_s2_d[i]) begin
                    stab_cnt[i] <= 8'd1;
                    if (FLEN == 8'd1) begin
                        filt[i] <= sync_s2[i];
                    end
                end else if (stab_cnt[i] != FLEN) begin
                    stab_cnt[i] <= stab_cnt[i] + 8'd1;
                    if (stab_cnt[i] + 8'd1 == FLEN) begin
                        filt[i] <= sync_s2[i];
                    end
                end
            end
        end
    end

    always_comb begin
        stable[0] = (stab_cnt[0] == FLEN);
        stable[1] = (stab_cnt[1] == FLEN);
    end

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic              primed;
    logic [1:0]        prev_state;
    logic [1:0]        pos_delta;
    logic              fwd;
    logic              rev;
    logic              illegal;
    logic              inc;
    logic              dec;
    logic signed [35:0] count_q;

    // Position difference modulo 4: 1 = forward, 3 = reverse, 2 = both bits flipped.
    always_comb begin
        pos_delta = gray_pos(filt) - gray_pos(prev_state);
        fwd       = primed && (pos_delta == 2'd1);
        rev       = primed && (pos_delta == 2'd3);
        illegal   = primed && (pos_delta == 2'd2);
        inc       = DIR_INVERT ? rev : fwd;
        dec       = DIR_INVERT ? fwd : rev;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            primed     <= 1'b0;
            prev_state <= '0;
            count_q    <= '0;
            direction  <= 1'b0;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            step_pulse <= fwd | rev;
            err_pulse  <= illegal;
            if (primed) begin
                prev_state <= filt;
            end else if (&stable) begin
                primed     <= 1'b1;
                prev_state <= filt;
            end
            if (clear) begin
                count_q <= '0;
            end else if (inc) begin
                count_q <= count_q + 36'sd1;
            end else if (dec) begin
                count_q <= count_q - 36'sd1;
            end
            if (inc) begin
                direction <= 1'b1;
            end else if (dec) begin
                direction <= 1'b0;
            end
            if (illegal && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_quadrature_counter.sv
// Randomised bench for quadrature_counter: a position-arithmetic model predicts count,
// direction, pulse totals and error count for a normal and a DIR_INVERT instance.
module tb_quadrature_counter;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enc_a;
    logic               enc_b;
    logic               clear;
    logic signed [35:0] count_a, count_b;
    logic               dir_a, dir_b;
    logic               step_a, step_b;
    logic               errp_a, errp_b;
    logic [7:0]         errc_a, errc_b;

    quadrature_counter #(.FILTER_LEN(4), .DIR_INVERT(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .count(count_a), .direction(dir_a), .step_pulse(step_a),
        .err_pulse(errp_a), .err_cnt(errc_a)
    );

    quadrature_counter #(.FILTER_LEN(4), .DIR_INVERT(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .count(count_b), .direction(dir_b), .step_pulse(step_b),
        .err_pulse(errp_b), .err_cnt(errc_b)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic signed [35:0] m_count, m_count_inv;
    logic               m_dir, m_dir_inv;
    int                 m_err_total;
    int                 m_steps;
    int                 m_errs;

    int n_step = 0;
    int n_err  = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always @(negedge clk) begin
        if (step_a) n_step++;
        if (errp_a) n_err++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gpos(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gstate(input int p);
        case (((p % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int exp_errcnt();
        return (m_err_total > 255) ? 255 : m_err_total;
    endfunction

    // Apply the model's view of a move from the present pins to {na,nb}.
    task automatic model_move(input logic na, input logic nb, input bit cleared);
        int d;
        d = (gpos(na, nb) - gpos(enc_a, enc_b) + 4) % 4;
        if (d == 1) begin
            m_count = m_count + 36'sd1; m_dir = 1'b1;
            m_count_inv = m_count_inv - 36'sd1; m_dir_inv = 1'b0;
            m_steps++;
        end else if (d == 3) begin
            m_count = m_count - 36'sd1; m_dir = 1'b0;
            m_count_inv = m_count_inv + 36'sd1; m_dir_inv = 1'b1;
            m_steps++;
        end else if (d == 2) begin
            m_err_total++;
            m_errs++;
        end
        if (cleared) begin
            m_count = '0;
            m_count_inv = '0;
        end
    endtask

    task automatic move(input logic na, input logic nb, input int hold);
        @(negedge clk);
        model_move(na, nb, 1'b0);
        enc_a = na;
        enc_b = nb;
        repeat (hold) @(negedge clk);
    endtask

    task automatic step_by(input int dp, input int hold);
        logic [1:0] ns;
        ns = gstate(gpos(enc_a, enc_b) + dp);
        move(ns[1], ns[0], hold);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, count_a, m_count);
        check({tag, ".dir"}, dir_a, m_dir);
        check({tag, ".errcnt"}, errc_a, exp_errcnt());
        check({tag, ".steps"}, n_step, m_steps);
        check({tag, ".errs"}, n_err, m_errs);
        check({tag, ".inv_count"}, count_b, m_count_inv);
        check({tag, ".inv_dir"}, dir_b, m_dir_inv);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        m_count = '0; m_count_inv = '0;
        m_dir = 1'b0; m_dir_inv = 1'b0;
        m_err_total = 0;
        check("rst.count", count_a, 0);
        check("rst.dir", dir_a, 0);
        check("rst.step", step_a, 0);
        check("rst.errp", errp_a, 0);
        check("rst.errcnt", errc_a, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = '0;
        m_count_inv = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic signed [35:0] old_cnt;
        logic [1:0]         ns;
        reset_n = 1'b0;
        enc_a = 1'b1;
        enc_b = 1'b1;
        clear = 1'b0;
        m_steps = 0;
        m_errs = 0;
        m_err_total = 0;

        // Pins high through reset: priming must not count or flag
        do_reset(5);
        check_all("prime11");

        for (int i = 0; i < 32; i++) step_by(1, 20);
        check_all("fwd32");
        for (int i = 0; i < 32; i++) step_by(-1, 20);
        check_all("rev32");

        // Latency: count moves on edge 7 after the pin change
        old_cnt = count_a;
        ns = gstate(gpos(enc_a, enc_b) + 1);
        @(negedge clk);
        model_move(ns[1], ns[0], 1'b0);
        enc_a = ns[1];
        enc_b = ns[0];
        repeat (6) @(posedge clk);
        #1 check("lat.edge6", count_a, old_cnt);
        @(posedge clk);
        #1 check("lat.edge7", count_a, m_count);
        check("lat.step7", step_a, 1);
        repeat (12) @(negedge clk);
        check_all("lat");

        // 3-cycle glitch on B is filtered out
        @(negedge clk);
        enc_b = ~enc_b;
        repeat (3) @(negedge clk);
        enc_b = ~enc_b;
        repeat (15) @(negedge clk);
        check_all("glitch");

        // Illegal 00 -> 11
        move(1'b0, 1'b0, 15);
        move(1'b1, 1'b1, 15);
        check_all("illegal");

        // clear colliding with a forward step at count 10
        pulse_clear();
        for (int i = 0; i < 10; i++) step_by(1, 12);
        check_all("cnt10");
        ns = gstate(gpos(enc_a, enc_b) + 1);
        @(negedge clk);
        model_move(ns[1], ns[0], 1'b1);
        enc_a = ns[1];
        enc_b = ns[0];
        repeat (6) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 check("clrstep.count", count_a, 0);
        check("clrstep.step", step_a, 1);
        check("clrstep.inv_count", count_b, 0);
        @(negedge clk);
        clear = 1'b0;
        repeat (10) @(negedge clk);
        check_all("clrstep");

        // Wrap around the signed 36-bit range
        @(negedge clk);
        force dut_a.count_q = 36'sh7_FFFF_FFFF;
        @(negedge clk);
        release dut_a.count_q;
        m_count = 36'sh7_FFFF_FFFF;
        repeat (2) @(negedge clk);
        check_all("preload");
        step_by(1, 12);
        check("wrap.up", count_a, 36'sh8_0000_0000);
        step_by(-1, 12);
        check("wrap.down", count_a, 36'sh7_FFFF_FFFF);
        check_all("wrap");

        // Random walk with glitches and occasional illegal jumps
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) step_by(1, $urandom_range(10, 25));
            else if (r <= 6) step_by(-1, $urandom_range(10, 25));
            else if (r == 7) step_by(2, $urandom_range(10, 25));
            else if (r == 8) begin
                int gl;
                bit ch;
                gl = $urandom_range(1, 3);
                ch = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (ch) enc_a = ~enc_a; else enc_b = ~enc_b;
                repeat (gl) @(negedge clk);
                if (ch) enc_a = ~enc_a; else enc_b = ~enc_b;
                repeat (12) @(negedge clk);
            end else begin
                repeat ($urandom_range(5, 15)) @(negedge clk);
            end
            check("rnd.count", count_a, m_count);
            if (i % 20 == 19) check_all("rnd");
        end

        // Saturate the error counter
        for (int i = 0; i < 300; i++) step_by(2, 10);
        check("sat.errcnt", errc_a, 255);
        check_all("sat");

        // Reset mid-operation re-primes without counting
        step_by(1, 12);
        do_reset(3);
        check_all("rerst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
